// File: rtl/clk_en_gen_pkg.sv
// Shared types for the clock-enable / reset sequencer.
package clk_en_gen_pkg;

   localparam int CH_W  = 3;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      WAIT_LOCK,
      HOLD,
      RUN
   } state_t;

endpackage

// File: rtl/clk_en_gen_phase_acc.sv
// One fractional clock-enable channel: phase accumulator plus
// registered carry strobe.
module phase_acc #(
   parameter int                   ACC_WIDTH   = 16,
   parameter logic [ACC_WIDTH-1:0] DEFAULT_INC =
      {1'b1, {(ACC_WIDTH-1){1'b0}}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [ACC_WIDTH-1:0] new_inc,
   input  logic                 clear,
   input  logic                 run,
   output logic                 en
);

   logic [ACC_WIDTH-1:0] inc;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, inc};

   // The increment is written independently of the accumulator, so a new
   // rate applies from the addition after the write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inc <= DEFAULT_INC;
         acc <= '0;
         en  <= 1'b0;
      end else begin
         if (load)
            inc <= new_inc;
         if (!run || clear) begin
            acc <= '0;
            en  <= 1'b0;
         end else begin
            acc <= sum[ACC_WIDTH-1:0];
            en  <= sum[ACC_WIDTH];
         end
      end
   end

endmodule

// File: rtl/clk_en_gen.sv
// Lock-qualified reset sequencer driving a bank of fractional
// clock-enable channels in the clk_2x domain.
module clk_en_gen
   import clk_en_gen_pkg::*;
#(
   parameter int                   CHANNELS    = 4,
   parameter int                   ACC_WIDTH   = 16,
   parameter logic [ACC_WIDTH-1:0] DEFAULT_INC =
      {1'b1, {(ACC_WIDTH-1){1'b0}}},
   parameter int                   LOCK_FILTER = 8,
   parameter int                   RESET_HOLD  = 16
) (
   input  logic                 clk_2x,
   input  logic                 reset,
   input  logic                 pll_locked,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [CH_W-1:0]      cfg_channel,
   input  logic [ACC_WIDTH-1:0] cfg_inc,
   input  logic                 phase_sync,
   output logic [CHANNELS-1:0]  en,
   output logic                 sys_reset,
   output logic                 lock_lost
);

   localparam logic [CNT_W-1:0] LF_LAST = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(RESET_HOLD - 1);

   logic             lock_m;
   logic             lock_s;
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             run;
   logic             wr;

   // Accumulators only advance on edges that keep us in RUN, so the
   // edge leaving RUN already shows en = 0.
   assign run = (state == RUN) && lock_s;
   assign wr  = cfg_valid && cfg_ready;

   always_ff @(posedge clk_2x or posedge reset) begin
      if (reset) begin
         lock_m    <= 1'b0;
         lock_s    <= 1'b0;
         state     <= WAIT_LOCK;
         cnt       <= '0;
         sys_reset <= 1'b1;
         lock_lost <= 1'b0;
         cfg_ready <= 1'b0;
      end else begin
         lock_m    <= pll_locked;
         lock_s    <= lock_m;
         cfg_ready <= 1'b1;
         unique case (state)
            WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt <= '0;
               end else if (cnt == LF_LAST) begin
                  state <= HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == RH_LAST) begin
                  state     <= RUN;
                  cnt       <= '0;
                  sys_reset <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state     <= WAIT_LOCK;
                  cnt       <= '0;
                  sys_reset <= 1'b1;
                  lock_lost <= 1'b1;
               end
            end
            default: begin
               state     <= WAIT_LOCK;
               cnt       <= '0;
               sys_reset <= 1'b1;
            end
         endcase
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      phase_acc #(
         .ACC_WIDTH   (ACC_WIDTH),
         .DEFAULT_INC (DEFAULT_INC)
      ) u_acc (
         .clk     (clk_2x),
         .rst     (reset),
         .load    (wr && (cfg_channel == CH_W'(i))),
         .new_inc (cfg_inc),
         .clear   (phase_sync),
         .run     (run),
         .en      (en[i])
      );
   end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen at default parameters.
module tb_clk_en_gen;

   logic        clk_2x = 1'b0;
   logic        reset;
   logic        pll_locked;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_channel;
   logic [15:0] cfg_inc;
   logic        phase_sync;
   logic [3:0]  en;
   logic        sys_reset;
   logic        lock_lost;

   int vecs = 0;
   int errs = 0;

   always #5 clk_2x = ~clk_2x;

   clk_en_gen dut (
      .clk_2x      (clk_2x),
      .reset       (reset),
      .pll_locked  (pll_locked),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_channel (cfg_channel),
      .cfg_inc     (cfg_inc),
      .phase_sync  (phase_sync),
      .en          (en),
      .sys_reset   (sys_reset),
      .lock_lost   (lock_lost)
   );

   task automatic tick();
      @(posedge clk_2x);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_cfg(input logic [2:0] ch, input logic [15:0] v);
      cfg_valid   = 1'b1;
      cfg_channel = ch;
      cfg_inc     = v;
      tick();
      cfg_valid   = 1'b0;
   endtask

   logic [3:0]  exp_a;
   logic [3:0]  exp_b;
   logic [16:0] m;

   initial begin
      reset       = 1'b1;
      pll_locked  = 1'b0;
      cfg_valid   = 1'b0;
      cfg_channel = '0;
      cfg_inc     = '0;
      phase_sync  = 1'b0;
      tick();
      tick();
      chk("rst_sys_reset", 32'(sys_reset), 32'd1);
      chk("rst_en", 32'(en), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_lock_lost", 32'(lock_lost), 32'd0);
      reset = 1'b0;
      tick();
      chk("cfg_ready_up", 32'(cfg_ready), 32'd1);

      // lock chatter: never long enough to pass the filter
      for (int i = 0; i < 60; i++) begin
         if (i % 5 == 0)
            pll_locked = ~pll_locked;
         tick();
         chk("chatter_sys_reset", 32'(sys_reset), 32'd1);
         chk("chatter_lock_lost", 32'(lock_lost), 32'd0);
      end
      pll_locked = 1'b0;
      repeat (4) tick();

      // first lock: sys_reset falls on edge 26
      pll_locked = 1'b1;
      repeat (25) tick();
      chk("lock_edge25", 32'(sys_reset), 32'd1);
      tick();
      chk("lock_edge26", 32'(sys_reset), 32'd0);
      exp_a = 4'h0;
      for (int k = 27; k <= 30; k++) begin
         tick();
         chk("half_rate", 32'(en), 32'(exp_a));
         exp_a = ~exp_a;
      end

      // channel 1 to quarter rate
      wr_cfg(3'd1, 16'h4000);
      chk("wr1_edge", 32'(en), 32'h0);
      exp_a = 4'hD;
      exp_b = 4'h2;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k % 2 == 0)
            chk("quarter", 32'(en), 32'(exp_a));
         else if (k % 4 == 1)
            chk("quarter", 32'(en), 32'(exp_b));
         else
            chk("quarter", 32'(en), 32'h0);
      end

      // channel 1 off
      wr_cfg(3'd1, 16'h0000);
      chk("off_edge", 32'(en), 32'hD);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("ch1_off", 32'(en[1]), 32'd0);
      end

      // lock drop in RUN
      pll_locked = 1'b0;
      tick();
      chk("drop_e1", 32'(sys_reset), 32'd0);
      tick();
      chk("drop_e2", 32'(sys_reset), 32'd0);
      tick();
      chk("drop_e3_rst", 32'(sys_reset), 32'd1);
      chk("drop_e3_en", 32'(en), 32'd0);
      chk("drop_e3_lost", 32'(lock_lost), 32'd1);
      chk("drop_ready", 32'(cfg_ready), 32'd1);

      // relock; increments must survive
      pll_locked = 1'b1;
      repeat (25) tick();
      chk("relock_e25", 32'(sys_reset), 32'd1);
      tick();
      chk("relock_e26", 32'(sys_reset), 32'd0);
      chk("relock_lost", 32'(lock_lost), 32'd1);
      tick();
      chk("relock_e27", 32'(en), 32'h0);
      tick();
      chk("relock_e28", 32'(en), 32'hD);

      // two channels at 0x5555 with different phases, then align
      wr_cfg(3'd0, 16'h5555);
      tick();
      wr_cfg(3'd1, 16'h5555);
      repeat (2) tick();
      phase_sync = 1'b1;
      tick();
      phase_sync = 1'b0;
      chk("sync_edge", 32'(en), 32'h0);
      m = '0;
      for (int k = 0; k < 12; k++) begin
         m = {1'b0, m[15:0]} + 17'h05555;
         tick();
         chk("sync_ch0", 32'(en[0]), 32'(m[16]));
         chk("sync_ch1", 32'(en[1]), 32'(m[16]));
      end

      // out-of-range channel, then sync with a write to channel 2
      chk("ch7_ready", 32'(cfg_ready), 32'd1);
      wr_cfg(3'd7, 16'h1234);
      phase_sync = 1'b1;
      wr_cfg(3'd2, 16'h4000);
      phase_sync = 1'b0;
      chk("sync_wr_edge", 32'(en), 32'h0);
      tick();
      chk("sw_e1", 32'(en), 32'h0);
      tick();
      chk("sw_e2", 32'(en), 32'h8);
      tick();
      chk("sw_e3", 32'(en), 32'h0);
      tick();
      chk("sw_e4", 32'(en), 32'hF);
      tick();
      chk("sw_e5", 32'(en), 32'h0);
      tick();
      chk("sw_e6", 32'(en), 32'h8);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
